// File: rtl/div_if.sv
// Request/response bundle between the ALU and the sequential divider.
// The ALU side (master) drives operands and control; the divider (slave)
// returns the registered result and a one-cycle done strobe.
interface div_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              start;
   logic              signed_div;
   logic              annul;
   logic [DATA_W-1:0] quotient;
   logic [DATA_W-1:0] remainder;
   logic              done;

   modport master (
      output a, b, start, signed_div, annul,
      input  quotient, remainder, done
   );

   modport slave (
      input  a, b, start, signed_div, annul,
      output quotient, remainder, done
   );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Signed division is done on magnitudes with a sign fix-up when the
// result is loaded; divide-by-zero short-circuits to all-ones / dividend.
module div_seq #(
   parameter int DATA_W = 32
) (
   input  logic clk,
   input  logic rst,
   div_if.slave bus
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_DIV_ZERO = 2'd1;
   localparam logic [1:0] S_DIV_ON   = 2'd2;
   localparam logic [1:0] S_DIV_END  = 2'd3;

   // Two's-complement magnitude of a value whose sign bit is set.
   function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x);
      logic [DATA_W-1:0] ux;
      ux = x;
      if (x < 0) begin
         return ~ux + 1'b1;
      end
      return ux;
   endfunction

   // Conditional negation used by the sign fix-up on output load.
   function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] x, input logic cond);
      if (cond) begin
         return ~x + 1'b1;
      end
      return x;
   endfunction

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] dvd_q, dvd_d;     // dividend, becomes the quotient as bits shift in
   logic [DATA_W-1:0] dvs_q, dvs_d;     // divisor magnitude
   logic [DATA_W:0]   prem_q, prem_d;   // 33-bit partial remainder
   logic              sign_a_q, sign_a_d;
   logic              sign_b_q, sign_b_d;
   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic              done_q, done_d;

   // One restoring step: shift, trial subtract, keep or restore.
   logic [DATA_W:0]   prem_shift;
   logic [DATA_W:0]   prem_diff;
   logic              q_bit;
   logic [DATA_W:0]   prem_step;
   logic [DATA_W-1:0] quo_step;

   always_comb begin
      prem_shift = {prem_q[DATA_W-1:0], dvd_q[DATA_W-1]};
      prem_diff  = prem_shift - {1'b0, dvs_q};
      q_bit      = ~prem_diff[DATA_W];
      prem_step  = q_bit ? prem_diff : prem_shift;
      quo_step   = {dvd_q[DATA_W-2:0], q_bit};
   end

   // Next-state and datapath update for the divide FSM.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      prem_d   = prem_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      quo_d    = quo_q;
      rem_d    = rem_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.annul) begin
               cnt_d  = '0;
               prem_d = '0;
               if (bus.b == '0) begin
                  // Keep the raw dividend: it is returned unchanged as the remainder.
                  dvd_d    = bus.a;
                  dvs_d    = '0;
                  sign_a_d = 1'b0;
                  sign_b_d = 1'b0;
                  state_d  = S_DIV_ZERO;
               end else begin
                  if (bus.signed_div) begin
                     dvd_d    = magnitude(bus.a);
                     dvs_d    = magnitude(bus.b);
                     sign_a_d = bus.a[DATA_W-1];
                     sign_b_d = bus.b[DATA_W-1];
                  end else begin
                     dvd_d    = bus.a;
                     dvs_d    = bus.b;
                     sign_a_d = 1'b0;
                     sign_b_d = 1'b0;
                  end
                  state_d = S_DIV_ON;
               end
            end
         end
         S_DIV_ZERO: begin
            if (bus.annul) begin
               state_d = S_IDLE;
            end else begin
               quo_d   = '1;
               rem_d   = dvd_q;
               state_d = S_DIV_END;
            end
         end
         S_DIV_ON: begin
            if (bus.annul) begin
               state_d = S_IDLE;
            end else begin
               prem_d = prem_step;
               dvd_d  = quo_step;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  quo_d   = neg_if(quo_step, sign_a_q ^ sign_b_q);
                  rem_d   = neg_if(prem_step[DATA_W-1:0], sign_a_q);
                  state_d = S_DIV_END;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      done_d = (state_d == S_DIV_END);
   end

   // State and datapath registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         prem_q   <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         quo_q    <= '0;
         rem_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         prem_q   <= prem_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         done_q   <= done_d;
      end
   end

   assign bus.quotient  = quo_q;
   assign bus.remainder = rem_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq with a queue-based scoreboard.
module tb_div_seq;

   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_fail;
   logic prev_done;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb[$];

   div_if #(.DATA_W(32)) bus();

   div_seq #(.DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (rst === 1'b1 && bus.done === 1'b1) begin
         chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no result", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", bus.quotient, e.q);
            chk("remainder", bus.remainder, e.r);
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end
      prev_done = bus.done;
   end

   // Present operands and raise start; the next edge accepts (DUT is idle).
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] q, input logic [31:0] r, input int lat);
      exp_t e;
      @(negedge clk);
      bus.a          = a;
      bus.b          = b;
      bus.signed_div = s;
      bus.start      = 1'b1;
      e.q = q; e.r = r; e.acc = cyc + 1; e.lat = lat;
      sb.push_back(e);
      @(posedge clk);
      #1;
      // Operands must be ignored once the division is running.
      bus.a = $urandom;
      bus.b = $urandom;
      bus.signed_div = ~s;
   endtask

   task automatic wait_done(input bit drop);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_cmp++;
         n_fail++;
         $display("FAIL done_timeout: got no done in 100 cycles expected one");
      end
      if (drop) bus.start = 1'b0;
   endtask

   initial begin
      exp_t e;
      cyc = 0; n_cmp = 0; n_fail = 0; prev_done = 1'b0;
      rst = 1'b0;
      bus.a = '0; bus.b = '0; bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
      #1;
      chk("reset_quotient", bus.quotient, 32'd0);
      chk("reset_remainder", bus.remainder, 32'd0);
      chk("reset_done", {31'd0, bus.done}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Accepting edge counts as edge 1: done follows edge 33 (normal) or edge 2 (by zero).
      issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 32);
      wait_done(1'b1);

      // Annul while DIV_ON counter is 10.
      @(negedge clk);
      bus.a = 32'd1000; bus.b = 32'd3; bus.signed_div = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.annul = 1'b1; bus.start = 1'b0;
      @(negedge clk);
      bus.annul = 1'b0;
      repeat (40) @(negedge clk);
      chk("annul_keeps_quotient", bus.quotient, 32'd14);
      chk("annul_keeps_remainder", bus.remainder, 32'd2);

      issue(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 32);
      wait_done(1'b1);

      issue(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32);
      wait_done(1'b1);
      issue(32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, 32);
      wait_done(1'b1);
      issue(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 32);
      wait_done(1'b1);

      // Most-negative / -1, then start held through DIV_END for a back-to-back divide.
      issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 32);
      wait_done(1'b0);
      bus.a = 32'hFFFFFFFF; bus.b = 32'd1; bus.signed_div = 1'b0;
      e.q = 32'hFFFFFFFF; e.r = 32'd0; e.acc = cyc + 2; e.lat = 32;
      sb.push_back(e);
      wait_done(1'b1);

      issue(32'h1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h1234, 1);
      wait_done(1'b1);

      // annul in IDLE outranks start; release annul and the held start is accepted.
      @(negedge clk);
      bus.a = 32'd5; bus.b = 32'd1; bus.signed_div = 1'b0;
      bus.start = 1'b1; bus.annul = 1'b1;
      repeat (3) @(negedge clk);
      bus.annul = 1'b0;
      e.q = 32'd5; e.r = 32'd0; e.acc = cyc + 1; e.lat = 32;
      sb.push_back(e);
      wait_done(1'b1);

      // Reset in the middle of a division.
      @(negedge clk);
      bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
      repeat (15) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("async_reset_quotient", bus.quotient, 32'd0);
      chk("async_reset_remainder", bus.remainder, 32'd0);
      chk("async_reset_done", {31'd0, bus.done}, 32'd0);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      issue(32'd50, 32'd8, 1'b0, 32'd6, 32'd2, 32);
      wait_done(1'b1);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 Port clk, input, 1, rising-edge clock for all state.
REQ-003 Port rst, input, 1, asynchronous active-low reset.
REQ-004 Port a, input, 32, dividend, sampled only on the accepting edge.
REQ-005 Port b, input, 32, divisor, sampled only on the accepting edge.
REQ-006 Port start, input, 1, request a division; held high by the ALU until done is seen.
REQ-007 Port signed_div, input, 1, 1 = two's-complement (DIV), 0 = unsigned (DIVU); sampled with a and b.
REQ-008 Port annul, input, 1, pipeline flush; abandons an in-flight division.
REQ-009 Port quotient, output, 32, registered quotient.
REQ-010 Port remainder, output, 32, registered remainder.
REQ-011 Port done, output, 1, registered; high for exactly one cycle when the result is valid.

Function
REQ-012 The FSM SHALL have four states: IDLE, DIV_ZERO, DIV_ON and DIV_END.
REQ-013 In IDLE, start=1 and annul=0 at an edge SHALL be the accepting edge: a, b and signed_div are latched; the iteration counter is cleared.
REQ-014 On the accepting edge, the next state SHALL be DIV_ZERO if b==0, else DIV_ON.
REQ-015 Signed mode SHALL latch |a| and |b| (two's-complement magnitude) plus the signs a[31] and b[31]; unsigned mode SHALL latch a and b unchanged with both signs 0.
REQ-016 Each DIV_ON edge SHALL perform one restoring step: shift the 33-bit partial remainder left, taking in the next dividend MSB; trial-subtract {1'b0,divisor}; if the result is non-negative, keep it and shift in quotient bit 1, else keep the old value and shift in 0.
REQ-017 DIV_ON SHALL last exactly 32 edges (counter 0..31); the edge with counter=31 SHALL move to DIV_END and load the output registers.
REQ-018 Sign fix-up SHALL be applied when loading outputs: quotient negated when sign_a^sign_b; remainder negated when sign_a (remainder takes the dividend's sign).
REQ-019 The case 0x80000000 / 0xFFFFFFFF in signed mode SHALL give quotient=0x80000000 and remainder=0, with no special case beyond magnitude arithmetic.
REQ-020 DIV_ZERO SHALL last one edge, then move to DIV_END loading quotient=0xFFFFFFFF and remainder=a as latched (raw, unsigned form), in both modes.
REQ-021 done SHALL be 1 only while in DIV_END; DIV_END SHALL go unconditionally to IDLE on the next edge.
REQ-022 Latency: done SHALL be high in the cycle after the 33rd edge following the accepting edge for a normal divide, and after the 2nd edge for divide-by-zero.
REQ-023 quotient and remainder SHALL hold their value from DIV_END until the next load into DIV_END; they SHALL NOT change on acceptance, on annul or in IDLE.
REQ-024 start SHALL be ignored outside IDLE; operands SHALL NOT be re-latched while busy.
REQ-025 annul=1 in DIV_ZERO or DIV_ON SHALL force IDLE on the next edge: no done pulse, outputs unchanged.
REQ-026 annul=1 in DIV_END SHALL still return to IDLE: the done pulse completes and outputs keep the loaded result.
REQ-027 annul=1 in IDLE SHALL block acceptance even if start=1, and annul SHALL take priority over start.
REQ-028 A start held high through IDLE after DIV_END SHALL be accepted as a new division; the caller drops start on done.

Reset
REQ-029 rst=0 SHALL immediately, without a clock edge, force state=IDLE, counter=0, done=0, quotient=0, remainder=0 and all latched operand/sign/partial registers to 0.
REQ-030 rst deasserted mid-division SHALL leave the block in IDLE; the next accepted start SHALL produce a correct result with no residue.

Verification
REQ-031 Unsigned 100/7, start held until done -> done 33 edges after acceptance, quotient=14, remainder=2, done high exactly 1 cycle.
REQ-032 Signed -7/2 (0xFFFFFFF9/0x2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; the same operands unsigned -> quotient=0x7FFFFFFC, remainder=1.
REQ-033 Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-034 Divide 0x1234/0 -> done 2 edges after acceptance, quotient=0xFFFFFFFF, remainder=0x1234.
REQ-035 annul pulse at DIV_ON counter=10 after a prior 100/7 result -> no done, outputs remain 14/2; a following 9/3 -> quotient=3, remainder=0.
REQ-036 rst pulsed low mid-DIV_ON -> outputs 0 and done 0 asynchronously; a subsequent 50/8 -> quotient=6, remainder=2 with normal latency.
